spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI slave endpoint directly downstream of the team's 32-bit SPI master, on the same clk domain.
- Consumes sck/csn/mo and returns mi.
- Deserialises one 32-bit MSB-first frame per csn assertion and presents it as rx_data/rx_valid.
- Serialises a pre-loaded tx word back on mi in the same frame.

Parameters:
- FRAME_BITS, 32, bits per frame; legal range 8..32.
- SYNC_STAGES, 2, synchroniser flops on sck/csn/mo; legal values 2 or 3.

Ports:
- clk  input  1  system clock; also samples the SPI pins.
- rst  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from master; idle low.
- csn  input  1  chip select from master; active low.
- mo  input  1  master-out serial data.
- mi  output  1  master-in serial data.
- tx_data  input  FRAME_BITS  word to return in the next frame.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  tx shadow register empty.
- rx_data  output  FRAME_BITS  last complete received frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1 at a clk edge): the following values are forced, regardless of pins.
  - mi=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
  - Shift registers, bit counter and tx shadow cleared; state IDLE.
- Synchronisation:
  - sck, csn and mo each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Edge detect = synchronised value XOR history.
  - Master sck high and low phases must each be at least 3 clk; shorter phases are out of spec.
- SPI mode 0:
  - Slave samples mo on each detected sck rising edge.
  - Slave updates mi on each detected sck falling edge.
  - Frames are MSB first.
- tx handshake:
  - tx_valid && tx_ready at a clk edge loads the tx shadow; tx_ready drops the next cycle.
  - tx_ready returns to 1 in the cycle after the shadow is consumed at frame start.
  - tx_valid while tx_ready=0 is ignored; the shadow keeps its value.
- States:
  - IDLE:
    - busy=0.
    - On detected csn fall:
      - tx shift register = shadow if full, else all zeros; shadow emptied.
      - mi = bit FRAME_BITS-1 of the loaded word on the next cycle.
      - bit counter = 0; go to SHIFT.
  - SHIFT:
    - busy=1.
    - Each sck rise: rx shift register = {rx_shift[FRAME_BITS-2:0], mo_sync}; counter +1.
    - Each sck fall: tx shift left by one; mi = new MSB.
    - When the counter reaches FRAME_BITS on a rise:
      - rx_data loads the full word; rx_valid=1 for exactly one cycle, the cycle after that rise is detected.
      - Go to DONE.
    - csn rise before FRAME_BITS bits: abort; rx_data and rx_valid untouched; go to IDLE.
  - DONE:
    - busy=1; further sck edges are ignored and mi holds 0.
    - On csn rise: go to IDLE, busy=0.
- Simultaneous csn rise and final sck rise in the same cycle: the frame counts as complete (rx_valid fires); the next state is IDLE.
- Same-cycle tx load at csn fall: the shadow state before that edge is used; a word loaded in that cycle waits for the next frame.
- csn held low with no sck: the block stays in SHIFT indefinitely; there is no timeout.
- rst asserted mid-frame: the block returns to IDLE immediately. The next frame begins only on a fresh csn fall seen after rst deasserts, so a csn already low at release is ignored until it goes high then low.
- mi is registered; it is driven only while busy=1 and is 0 otherwise.

Optional Feature:
- Macro: SPI_SLV_ERR_EN.
- When defined, three extra outputs are added:
  - err_abort: one-cycle pulse on a mid-frame csn rise.
  - err_underrun: one-cycle pulse at csn fall when the shadow is empty.
  - err_extra: one-cycle pulse on the first sck rise seen in DONE.
  - All three reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Load tx_data=32'h1234_5678, then run a full frame with mo sending 32'hA5A5_A5A5 at 8 clk per sck phase -> mi carries 32'h1234_5678 MSB first; rx_data=32'hA5A5_A5A5; rx_valid is high for exactly 1 cycle; busy falls after csn rises.
- Back-to-back frames with tx words 32'hDEAD_BEEF and 32'h0000_0001, with the second word loaded mid-frame 1 -> frame 2 returns 32'h0000_0001; tx_ready=0 from the load until frame 2 starts.
- No tx load, then a frame -> mi stays 0 for all 32 bits; tx_ready stays 1; err_underrun pulses if SPI_SLV_ERR_EN is defined.
- csn raised after 17 bits of 32'hFFFF_FFFF -> no rx_valid; rx_data keeps its previous value; next frame 32'h0F0F_0F0F is received correctly.
- 34 sck pulses in one csn window -> exactly one rx_valid, carrying the first 32 bits; err_extra pulses once if SPI_SLV_ERR_EN is defined.
- rst pulsed at bit 10 with csn still low -> all outputs at reset values; no frame until csn rises then falls, after which a full frame is received normally.

Source files
------------

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// SPI mode-0 slave endpoint running on the system clock. sck/csn/mo are
// oversampled through a synchroniser chain. Each csn-low window carries one
// MSB-first frame: the received word is presented on rx_data with a one-cycle
// rx_valid pulse. The word pre-loaded through the tx handshake is shifted back
// out on mi during the same frame.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sck, csn, mo     SPI pins from the master (sck idle low, csn active low)
//   mi               registered master-in data, 0 whenever busy is low
//   tx_data/tx_valid word offered for the next frame; tx_ready = shadow empty
//   rx_data/rx_valid last complete frame, one-cycle pulse on update
//   busy             high from frame start until csn returns high
//
// Optional feature (macro SPI_SLV_ERR_EN): adds err_abort, err_underrun and
// err_extra one-cycle pulse outputs.
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  csn,
  input  logic                  mo,
  output logic                  mi,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLV_ERR_EN
  output logic                  err_abort,
  output logic                  err_underrun,
  output logic                  err_extra,
`endif
  output logic                  busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Synchroniser chain, bit order {sck, csn, mo}. Reset to all zeros so that
  // a csn already low when rst releases produces no falling edge: a new
  // frame needs csn to go high and then low again.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] stage_in;
      logic [2:0] stage_reg;
      if (gi == 0) begin : g_in
        assign stage_in = {sck, csn, mo};
      end else begin : g_chain
        assign stage_in = g_sync[gi-1].stage_reg;
      end
      always_ff @(posedge clk) begin
        if (rst) stage_reg <= '0;
        else     stage_reg <= stage_in;
      end
    end
  endgenerate

  logic [2:0] pins_sync;
  logic [1:0] hist_reg;   // {sck, csn} history for edge detection
  assign pins_sync = g_sync[SYNC_STAGES-1].stage_reg;

  always_ff @(posedge clk) begin
    if (rst) hist_reg <= '0;
    else     hist_reg <= pins_sync[2:1];
  end

  logic sck_rise, sck_fall, csn_rise, csn_fall, mo_s;
  assign sck_rise = pins_sync[2] & ~hist_reg[1];
  assign sck_fall = ~pins_sync[2] & hist_reg[1];
  assign csn_rise = pins_sync[1] & ~hist_reg[0];
  assign csn_fall = ~pins_sync[1] & hist_reg[0];
  assign mo_s     = pins_sync[0];

  state_t                state_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  // Both shift registers hold FRAME_BITS-1 bits: the rx word is completed
  // with the current mo sample, and the current tx MSB already sits in mi_reg.
  logic [FRAME_BITS-2:0] rx_shift_reg;
  logic [FRAME_BITS-2:0] tx_shift_reg;
  logic [FRAME_BITS-1:0] shadow_reg;
  logic                  shadow_full_reg;
  logic                  mi_reg;
  logic [FRAME_BITS-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  busy_reg;
`ifdef SPI_SLV_ERR_EN
  logic                  err_abort_reg;
  logic                  err_underrun_reg;
  logic                  err_extra_reg;
  logic                  extra_seen_reg;
`endif

  logic last_bit;
  assign last_bit = (bit_cnt_reg == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      mi_reg          <= 1'b0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef SPI_SLV_ERR_EN
      err_abort_reg    <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_extra_reg    <= 1'b0;
      extra_seen_reg   <= 1'b0;
`endif
    end else begin
      rx_valid_reg <= 1'b0;
`ifdef SPI_SLV_ERR_EN
      err_abort_reg    <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_extra_reg    <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          mi_reg   <= 1'b0;
          if (csn_fall) begin
            // Uses the shadow as it was before this edge; an empty shadow
            // sends an all-zero word.
            tx_shift_reg    <= shadow_full_reg ? shadow_reg[FRAME_BITS-2:0] : '0;
            mi_reg          <= shadow_full_reg & shadow_reg[FRAME_BITS-1];
            shadow_full_reg <= 1'b0;
            bit_cnt_reg     <= '0;
            busy_reg        <= 1'b1;
            state_reg       <= SHIFT;
`ifdef SPI_SLV_ERR_EN
            err_underrun_reg <= ~shadow_full_reg;
            extra_seen_reg   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_shift_reg <= {rx_shift_reg[FRAME_BITS-3:0], mo_s};
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (last_bit) begin
              rx_data_reg  <= {rx_shift_reg, mo_s};
              rx_valid_reg <= 1'b1;
              mi_reg       <= 1'b0;
              state_reg    <= DONE;
            end
          end else if (sck_fall) begin
            mi_reg       <= tx_shift_reg[FRAME_BITS-2];
            tx_shift_reg <= {tx_shift_reg[FRAME_BITS-3:0], 1'b0};
          end
          // A csn rise coinciding with the final sck rise still completes the
          // frame above; either way the block returns to IDLE.
          if (csn_rise) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            mi_reg    <= 1'b0;
`ifdef SPI_SLV_ERR_EN
            err_abort_reg <= ~(sck_rise & last_bit);
`endif
          end
        end
        DONE: begin
          mi_reg <= 1'b0;
`ifdef SPI_SLV_ERR_EN
          if (sck_rise && !extra_seen_reg) begin
            err_extra_reg  <= 1'b1;
            extra_seen_reg <= 1'b1;
          end
`endif
          if (csn_rise) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          mi_reg    <= 1'b0;
        end
      endcase

      // Placed last so a load in the same cycle as a frame-start consume
      // wins: that word is kept for the following frame.
      if (tx_valid && !shadow_full_reg) begin
        shadow_reg      <= tx_data;
        shadow_full_reg <= 1'b1;
      end
    end
  end

  assign mi       = mi_reg;
  assign tx_ready = ~shadow_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = busy_reg;
`ifdef SPI_SLV_ERR_EN
  assign err_abort    = err_abort_reg;
  assign err_underrun = err_underrun_reg;
  assign err_extra    = err_extra_reg;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Drives a mode-0 SPI master model (8 clk per sck phase) into spi_slave_rx.
// Expected received words go into exp_q as frames are driven; a monitor
// collects every rx_valid cycle into rx_seen, and each scenario task pops and
// compares. mi is sampled just before each sck rise into mi_cap.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst, sck, csn, mo, mi;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, busy;
`ifdef SPI_SLV_ERR_EN
  logic        err_abort, err_underrun, err_extra;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [$];
  logic [31:0] rx_seen [$];
  logic [31:0] mi_cap;
  int abort_cnt = 0, underrun_cnt = 0, extra_cnt = 0;

  spi_slave_rx #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .csn(csn), .mo(mo), .mi(mi),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLV_ERR_EN
    .err_abort(err_abort), .err_underrun(err_underrun), .err_extra(err_extra),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_seen.push_back(rx_data);
`ifdef SPI_SLV_ERR_EN
    if (err_abort === 1'b1)    abort_cnt++;
    if (err_underrun === 1'b1) underrun_cnt++;
    if (err_extra === 1'b1)    extra_cnt++;
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [31:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic csn_low(input logic [31:0] w);
    @(negedge clk);
    csn    = 1'b0;
    mo     = w[31];
    mi_cap = '0;
    wait_clk(HALF);
  endtask

  task automatic send_bits(input logic [31:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      if (i < 32) mi_cap[31-i] = mi;
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      if (i < 31) mo = w[30-i];
      else        mo = 1'b0;
      wait_clk(HALF);
    end
  endtask

  task automatic csn_high();
    csn = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1; csn = 1'b0; sck = 1'b0; mo = 1'b1;
    wait_clk(3);
    checks++; if (mi !== 1'b0)       begin errors++; $display("FAIL reset_mi: got %b want 0", mi); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; csn = 1'b1; mo = 1'b0;
    wait_clk(HALF);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    got = 32'(rx_seen.size());
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL reset_no_rx: got %0d pulses want 0", got); end
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [31:0] got, want;
    exp_q.push_back(32'hA5A5_A5A5);
    load_tx(32'h1234_5678);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_tx_ready_low: got %b want 0", tx_ready); end
    csn_low(32'hA5A5_A5A5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", busy); end
    send_bits(32'hA5A5_A5A5, 0, 32);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    checks++; if (mi_cap !== 32'h1234_5678) begin errors++; $display("FAIL basic_mi: got %h want 12345678", mi_cap); end
    csn_high();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    checks++; if (mi !== 1'b0)   begin errors++; $display("FAIL basic_mi_idle: got %b want 0", mi); end
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL basic_rx_count: got %0d want 1", rx_seen.size()); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL basic_rx_word: got %h want %h", got, want); end
    checks++; if (rx_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL basic_rx_data: got %h want a5a5a5a5", rx_data); end
    $display("basic: tx=12345678 mi=%h rx=%h", mi_cap, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, want;
    load_tx(32'hDEAD_BEEF);
    exp_q.push_back(32'h1357_9BDF);
    csn_low(32'h1357_9BDF);
    send_bits(32'h1357_9BDF, 0, 16);
    load_tx(32'h0000_0001);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_tx_ready_load: got %b want 0", tx_ready); end
    send_bits(32'h1357_9BDF, 16, 16);
    csn_high();
    checks++; if (mi_cap !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_mi1: got %h want deadbeef", mi_cap); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_tx_ready_gap: got %b want 0", tx_ready); end
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL b2b_rx1_count: got %0d want 1", rx_seen.size()); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL b2b_rx1_word: got %h want %h", got, want); end
    $display("b2b frame1: mi=%h rx=%h", mi_cap, got);
    exp_q.push_back(32'h2468_ACE0);
    csn_low(32'h2468_ACE0);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_tx_ready_frame2: got %b want 1", tx_ready); end
    send_bits(32'h2468_ACE0, 0, 32);
    csn_high();
    checks++; if (mi_cap !== 32'h0000_0001) begin errors++; $display("FAIL b2b_mi2: got %h want 00000001", mi_cap); end
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL b2b_rx2_count: got %0d want 1", rx_seen.size()); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL b2b_rx2_word: got %h want %h", got, want); end
    $display("b2b frame2: mi=%h rx=%h", mi_cap, got);
  endtask

  task automatic test_no_tx();
    logic [31:0] got, want;
    int under0;
    under0 = underrun_cnt;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL notx_tx_ready_before: got %b want 1", tx_ready); end
    exp_q.push_back(32'h3C3C_5AA5);
    csn_low(32'h3C3C_5AA5);
    send_bits(32'h3C3C_5AA5, 0, 32);
    csn_high();
    checks++; if (mi_cap !== 32'h0) begin errors++; $display("FAIL notx_mi: got %h want 00000000", mi_cap); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL notx_tx_ready_after: got %b want 1", tx_ready); end
`ifdef SPI_SLV_ERR_EN
    checks++; if (underrun_cnt - under0 != 1) begin errors++; $display("FAIL notx_underrun: got %0d pulses want 1", underrun_cnt - under0); end
`endif
    want = exp_q.pop_front();
    got  = (rx_seen.size() == 1) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL notx_rx_word: got %h want %h", got, want); end
    $display("notx: mi=%h rx=%h underruns=%0d", mi_cap, got, underrun_cnt - under0);
  endtask

  task automatic test_abort();
    logic [31:0] got, want;
    int abort0;
    abort0 = abort_cnt;
    csn_low(32'hFFFF_FFFF);
    send_bits(32'hFFFF_FFFF, 0, 17);
    csn_high();
    checks++; if (rx_seen.size() != 0) begin errors++; $display("FAIL abort_rx_count: got %0d want 0", rx_seen.size()); end
    checks++; if (rx_data !== 32'h3C3C_5AA5) begin errors++; $display("FAIL abort_rx_data: got %h want 3c3c5aa5", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
`ifdef SPI_SLV_ERR_EN
    checks++; if (abort_cnt - abort0 != 1) begin errors++; $display("FAIL abort_err: got %0d pulses want 1", abort_cnt - abort0); end
`endif
    rx_seen.delete();
    $display("abort: 17 bits, rx_data=%h", rx_data);
    exp_q.push_back(32'h0F0F_0F0F);
    csn_low(32'h0F0F_0F0F);
    send_bits(32'h0F0F_0F0F, 0, 32);
    csn_high();
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL abort_next_count: got %0d want 1", rx_seen.size()); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL abort_next_word: got %h want %h", got, want); end
    $display("abort next: rx=%h", got);
  endtask

  task automatic test_extra();
    logic [31:0] got, want;
    int extra0;
    extra0 = extra_cnt;
    exp_q.push_back(32'h96C3_5A17);
    csn_low(32'h96C3_5A17);
    send_bits(32'h96C3_5A17, 0, 34);
    csn_high();
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL extra_rx_count: got %0d want 1", rx_seen.size()); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL extra_rx_word: got %h want %h", got, want); end
`ifdef SPI_SLV_ERR_EN
    checks++; if (extra_cnt - extra0 != 1) begin errors++; $display("FAIL extra_err: got %0d pulses want 1", extra_cnt - extra0); end
`endif
    $display("extra: 34 pulses rx=%h", got);
  endtask

  task automatic test_rst_mid();
    logic [31:0] got, want;
    load_tx(32'h7777_1111);
    csn_low(32'hC3C3_C3C3);
    send_bits(32'hC3C3_C3C3, 0, 10);
    rst = 1'b1;
    wait_clk(2);
    checks++; if (mi !== 1'b0)       begin errors++; $display("FAIL rstmid_mi: got %b want 0", mi); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL rstmid_rx_data: got %h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    rst = 1'b0;
    send_bits(32'hC3C3_C3C3, 10, 8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale_csn_busy: got %b want 0", busy); end
    csn_high();
    checks++; if (rx_seen.size() != 0) begin errors++; $display("FAIL rstmid_no_rx: got %0d want 0", rx_seen.size()); end
    rx_seen.delete();
    load_tx(32'hCAFE_F00D);
    exp_q.push_back(32'h5A5A_0FF0);
    csn_low(32'h5A5A_0FF0);
    send_bits(32'h5A5A_0FF0, 0, 32);
    csn_high();
    checks++; if (mi_cap !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_mi: got %h want cafef00d", mi_cap); end
    want = exp_q.pop_front();
    got  = (rx_seen.size() == 1) ? rx_seen.pop_front() : 32'hxxxx_xxxx;
    rx_seen.delete();
    checks++; if (got !== want) begin errors++; $display("FAIL rstmid_rx_word: got %h want %h", got, want); end
    $display("rst_mid: recovery frame mi=%h rx=%h", mi_cap, got);
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; csn = 1'b1; mo = 1'b0;
    tx_data = '0; tx_valid = 1'b0; mi_cap = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_tx();
    test_abort();
    test_extra();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
